// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit words and streams them into instruction memory.
// Optional running XOR checksum output enabled by defining INSTR_ENCODER_CHECKSUM_EN.
module instr_encoder #(
    parameter int bits   = 32,
    parameter int memory = 10,
    parameter int addr   = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [20:0]       imm,
    input  logic [addr-1:0]   address,
    output logic              mem_we,
    output logic [memory-1:0] mem_addr,
    output logic [bits-1:0]   mem_data,
    output logic [memory:0]   word_count,
    output logic              full,
    output logic              err_illegal,
    output logic              err_range
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [memory-1:0] PTR_MAX   = '1;
    localparam logic [memory-1:0] PTR_ONE   = 1;
    localparam logic [memory:0]   COUNT_ONE = 1;

    state_t            state;
    state_t            state_next;
    logic [memory-1:0] ptr;
    logic [bits-1:0]   encoded;
    logic              accept;
    logic              legal;
    logic              range_bad;

    assign accept    = in_valid && in_ready;
    assign legal     = (opcode <= 6'd17);
    assign range_bad = ((opcode == 6'd6) || (opcode == 6'd7)) && (address[addr-1:16] != '0);

    always_comb begin
        encoded = '0;
        encoded[31:26] = opcode;
        case (opcode)
            6'd0: begin
                encoded[25:21] = rd;
                encoded[20:16] = rs;
                encoded[15:11] = rt;
                encoded[5:0]   = funct;
            end
            6'd1, 6'd10: begin
                encoded[25:21] = rd;
                encoded[19:0]  = address[19:0];
            end
            6'd2: begin
                encoded[25:21] = rd;
                encoded[20:0]  = imm;
            end
            6'd3: begin
                encoded[25:21] = rs;
                encoded[19:0]  = address[19:0];
            end
            6'd4, 6'd5: begin
                encoded[25:21] = rd;
                encoded[20:16] = rs;
                encoded[10:6]  = shamt;
            end
            6'd6, 6'd7: begin
                encoded[25:21] = rs;
                encoded[20:16] = rt;
                encoded[15:0]  = address[15:0];
            end
            6'd8:               encoded[19:0]  = address[19:0];
            6'd9, 6'd12, 6'd15: encoded[25:21] = rs;
            6'd13, 6'd17: begin
                encoded[25:21] = rs;
                encoded[20:16] = rt;
            end
            6'd14:              encoded[25:21] = rd;
            6'd16: begin
                encoded[25:21] = rd;
                encoded[20:16] = rt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && legal) state_next = WRITE;
                WRITE:   state_next = (ptr == PTR_MAX) ? FULL : IDLE;
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    // A clear arriving during WRITE suppresses that cycle's strobe.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        full     = 1'b0;
        case (state)
            IDLE:    in_ready = !clear;
            WRITE:   mem_we   = !clear;
            FULL:    full     = 1'b1;
            default: ;
        endcase
    end

    // The pointer saturates at the last address; FULL is the only way out of that slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            word_count  <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else if (clear) begin
            ptr         <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            if (accept) begin
                if (!legal) begin
                    err_illegal <= 1'b1;
                end else begin
                    mem_data <= encoded;
                    mem_addr <= ptr;
                    if (range_bad) err_range <= 1'b1;
                end
            end
            if (state == WRITE) begin
                if (ptr != PTR_MAX) ptr <= ptr + PTR_ONE;
                word_count <= word_count + COUNT_ONE;
            end
        end
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  checksum <= '0;
        else if (clear)              checksum <= '0;
        else if (state == WRITE)     checksum <= checksum ^ mem_data[31:0];
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a field-table model checked every cycle plus hand-computed literals.
// Covers the INSTR_ENCODER_CHECKSUM_EN build when that macro is defined.
module tb_instr_encoder;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [20:0] imm;
    logic [19:0] address;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [10:0] word_count;
    logic        full;
    logic        err_illegal;
    logic        err_range;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    instr_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .address     (address),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .word_count  (word_count),
        .full        (full),
        .err_illegal (err_illegal),
        .err_range   (err_range)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (actual === expected) n_pass = n_pass + 1;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    endtask

    // Field placement straight from the opcode table, built with shifts of whole fields.
    function automatic logic [31:0] model_encode(input logic [31:0] op, input logic [31:0] f_rd,
                                                 input logic [31:0] f_rs, input logic [31:0] f_rt,
                                                 input logic [31:0] f_sh, input logic [31:0] f_fn,
                                                 input logic [31:0] f_imm, input logic [31:0] f_ad);
        logic [31:0] w;
        w = op << 26;
        case (op)
            0:          w = w | (f_rd << 21) | (f_rs << 16) | (f_rt << 11) | f_fn;
            1, 10:      w = w | (f_rd << 21) | f_ad;
            2:          w = w | (f_rd << 21) | f_imm;
            3:          w = w | (f_rs << 21) | f_ad;
            4, 5:       w = w | (f_rd << 21) | (f_rs << 16) | (f_sh << 6);
            6, 7:       w = w | (f_rs << 21) | (f_rt << 16) | (f_ad & 32'h0000_FFFF);
            8:          w = w | f_ad;
            9, 12, 15:  w = w | (f_rs << 21);
            13, 17:     w = w | (f_rs << 21) | (f_rt << 16);
            14:         w = w | (f_rd << 21);
            16:         w = w | (f_rd << 21) | (f_rt << 16);
            default:    w = w;
        endcase
        return w;
    endfunction

    logic        m_pending;
    logic        m_full;
    logic        m_ill;
    logic        m_rng;
    logic [31:0] m_word;
    logic [31:0] m_csum;
    int          m_addr;
    int          m_next;
    int          m_count;

    // Model: a request occupies the memory port for one cycle, then the next slot opens.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pending <= 1'b0;
            m_full    <= 1'b0;
            m_ill     <= 1'b0;
            m_rng     <= 1'b0;
            m_word    <= '0;
            m_csum    <= '0;
            m_addr    <= 0;
            m_next    <= 0;
            m_count   <= 0;
        end else if (clear) begin
            m_pending <= 1'b0;
            m_full    <= 1'b0;
            m_ill     <= 1'b0;
            m_rng     <= 1'b0;
            m_csum    <= '0;
            m_next    <= 0;
            m_count   <= 0;
        end else if (m_pending) begin
            m_pending <= 1'b0;
            m_csum    <= m_csum ^ m_word;
            m_count   <= m_count + 1;
            if (m_next == 1023) m_full <= 1'b1;
            else                m_next <= m_next + 1;
        end else if (!m_full && in_valid) begin
            if (opcode > 17) begin
                m_ill <= 1'b1;
            end else begin
                m_pending <= 1'b1;
                m_addr    <= m_next;
                m_word    <= model_encode(32'(opcode), 32'(rd), 32'(rs), 32'(rt), 32'(shamt),
                                          32'(funct), 32'(imm), 32'(address));
                if ((opcode == 6 || opcode == 7) && address >= 20'h10000) m_rng <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            check_output("in_ready",    32'(in_ready),    32'(!m_pending && !m_full && !clear));
            check_output("mem_we",      32'(mem_we),      32'(m_pending && !clear));
            check_output("mem_addr",    32'(mem_addr),    32'(m_addr));
            check_output("mem_data",    mem_data,         m_word);
            check_output("word_count",  32'(word_count),  32'(m_count));
            check_output("full",        32'(full),        32'(m_full));
            check_output("err_illegal", 32'(err_illegal), 32'(m_ill));
            check_output("err_range",   32'(err_range),   32'(m_rng));
`ifdef INSTR_ENCODER_CHECKSUM_EN
            check_output("checksum",    checksum,         m_csum);
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] a_op, input logic [4:0] a_rd, input logic [4:0] a_rs,
                                  input logic [4:0] a_rt, input logic [4:0] a_sh, input logic [5:0] a_fn,
                                  input logic [20:0] a_imm, input logic [19:0] a_ad);
        opcode   = a_op;
        rd       = a_rd;
        rs       = a_rs;
        rt       = a_rt;
        shamt    = a_sh;
        funct    = a_fn;
        imm      = a_imm;
        address  = a_ad;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        opcode = '0; rd = '0; rs = '0; rt = '0; shamt = '0; funct = '0; imm = '0; address = '0;
        #3;
        check_output("rst mem_we",     32'(mem_we),     32'h0);
        check_output("rst mem_data",   mem_data,        32'h0);
        check_output("rst word_count", 32'(word_count), 32'h0);
        check_output("rst full",       32'(full),       32'h0);
        #9;
        reset = 1'b1;
        #1;
        check_output("ready after reset", 32'(in_ready), 32'h1);
        tick();

        // LOADI
        apply_stimulus(6'd2, 5'd3, 5'd0, 5'd0, 5'd0, 6'd0, 21'h1FFFFF, 20'h0);
        @(negedge clock);
        check_output("loadi mem_we",   32'(mem_we),   32'h1);
        check_output("loadi mem_data", mem_data,      32'h087F_FFFF);
        check_output("loadi mem_addr", 32'(mem_addr), 32'h0);
        tick();
        @(negedge clock);
        check_output("loadi strobe drop", 32'(mem_we),     32'h0);
        check_output("loadi count",       32'(word_count), 32'h1);
        tick();

        // Back-to-back with in_valid held high
        do_clear();
        opcode = 6'd0; rd = 5'd1; rs = 5'd2; rt = 5'd3; shamt = 5'd7; funct = 6'h20;
        imm = 21'h0; address = 20'h0;
        in_valid = 1'b1;
        tick();
        opcode = 6'd4; rd = 5'd5; rs = 5'd6; rt = 5'd31; shamt = 5'd9; funct = 6'h3F;
        @(negedge clock);
        check_output("b2b w0 mem_we",   32'(mem_we),   32'h1);
        check_output("b2b w0 mem_addr", 32'(mem_addr), 32'h0);
        check_output("b2b w0 mem_data", mem_data,      32'h0022_1820);
        check_output("b2b w0 in_ready", 32'(in_ready), 32'h0);
        tick();
        @(negedge clock);
        check_output("b2b gap mem_we",   32'(mem_we),   32'h0);
        check_output("b2b gap in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        check_output("b2b w1 mem_we",   32'(mem_we),   32'h1);
        check_output("b2b w1 mem_addr", 32'(mem_addr), 32'h1);
        check_output("b2b w1 mem_data", mem_data,      32'h10A6_0240);
        check_output("b2b w1 in_ready", 32'(in_ready), 32'h0);
        tick();

        // Illegal opcode then opcode 11
        do_clear();
        apply_stimulus(6'd20, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 21'h1, 20'h1);
        @(negedge clock);
        check_output("illegal flag",   32'(err_illegal), 32'h1);
        check_output("illegal mem_we", 32'(mem_we),      32'h0);
        check_output("illegal count",  32'(word_count),  32'h0);
        tick();
        apply_stimulus(6'd11, 5'd7, 5'd7, 5'd7, 5'd7, 6'd7, 21'h7, 20'h7);
        @(negedge clock);
        check_output("op11 mem_data", mem_data,      32'h2C00_0000);
        check_output("op11 mem_addr", 32'(mem_addr), 32'h0);
        check_output("op11 mem_we",   32'(mem_we),   32'h1);
        tick();

        // Fill the whole memory
        do_clear();
        for (int i = 0; i < 1024; i++) begin
            apply_stimulus(6'(i % 18), 5'(i), 5'(i >> 2), 5'(i * 3), 5'(i * 5), 6'(i * 7),
                           21'(i * 2053), 20'(i * 1031));
            tick();
        end
        @(negedge clock);
        check_output("fill full",     32'(full),       32'h1);
        check_output("fill in_ready", 32'(in_ready),   32'h0);
        check_output("fill count",    32'(word_count), 32'd1024);
        tick();
        apply_stimulus(6'd11, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 21'h0, 20'h0);
        @(negedge clock);
        check_output("full extra mem_we", 32'(mem_we),     32'h0);
        check_output("full extra count",  32'(word_count), 32'd1024);
        tick();
        do_clear();
        @(negedge clock);
        check_output("clear full", 32'(full), 32'h0);
        apply_stimulus(6'd14, 5'd9, 5'd0, 5'd0, 5'd0, 6'd0, 21'h0, 20'h0);
        @(negedge clock);
        check_output("after clear mem_addr", 32'(mem_addr), 32'h0);
        check_output("after clear mem_data", mem_data,      32'h3920_0000);
        tick();

        // BEQ with out-of-range target
        apply_stimulus(6'd6, 5'd0, 5'd1, 5'd2, 5'd0, 6'd0, 21'h0, 20'h12345);
        @(negedge clock);
        check_output("beq err_range", 32'(err_range),       32'h1);
        check_output("beq low half",  32'(mem_data[15:0]),  32'h2345);
        check_output("beq mem_data",  mem_data,             32'h1822_2345);
        tick();

        // Asynchronous reset in the middle of a WRITE
        apply_stimulus(6'd1, 5'd4, 5'd0, 5'd0, 5'd0, 6'd0, 21'h0, 20'hABCDE);
        #2;
        check_output("midwrite mem_we before", 32'(mem_we), 32'h1);
        reset = 1'b0;
        #1;
        check_output("async mem_we",      32'(mem_we),      32'h0);
        check_output("async mem_addr",    32'(mem_addr),    32'h0);
        check_output("async mem_data",    mem_data,         32'h0);
        check_output("async word_count",  32'(word_count),  32'h0);
        check_output("async full",        32'(full),        32'h0);
        check_output("async err_range",   32'(err_range),   32'h0);
        check_output("async err_illegal", 32'(err_illegal), 32'h0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        check_output("async checksum",    checksum,         32'h0);
`endif
        #3;
        reset = 1'b1;
        #1;
        check_output("ready after midwrite reset", 32'(in_ready), 32'h1);
        tick();

`ifdef INSTR_ENCODER_CHECKSUM_EN
        apply_stimulus(6'd0, 5'd0, 5'd0, 5'd31, 5'd0, 6'd63, 21'h0, 20'h0);
        tick();
        apply_stimulus(6'd2, 5'd31, 5'd0, 5'd0, 5'd0, 6'd0, 21'h1FFFFF, 20'h0);
        tick();
        @(negedge clock);
        check_output("checksum xor", checksum, 32'h0BFF_07C0);
        tick();
        do_clear();
        @(negedge clock);
        check_output("checksum clear", checksum, 32'h0);
        tick();
`endif

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
